// File: rtl/shift_ex_stage_if.sv
// Operand/result handshake bundle for the shift execute stage.
// The master drives operations and consumes results; the slave is the stage itself.
interface shift_ex_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_z;
    logic        out_n;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_data, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_z, out_n, out_err
    );

    modport slave (
        input  in_valid, in_op, in_data, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_z, out_n, out_err
    );
endinterface

// File: rtl/shift_ex_stage.sv
// Two-stage shift execute pipeline: S1 captures the operation, S2 holds the result
// and flags. Ready/valid on both sides, with flush and synchronous reset.
module shift_ex_stage (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    shift_ex_stage_if.slave bus
);
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRA = 2'b01,
        OP_ROR = 2'b10,
        OP_ILL = 2'b11
    } op_e;

    typedef struct packed {
        logic [15:0] data;
        logic        z;
        logic        n;
        logic        err;
    } result_t;

    localparam result_t RESULT_ZERO = '{data: 16'h0000, z: 1'b1, n: 1'b0, err: 1'b0};

    logic        s1_valid;
    op_e         s1_op;
    logic [15:0] s1_data;
    logic [3:0]  s1_amt;
    logic        s2_valid;
    result_t     s2_res;
    result_t     s1_res;
    logic [31:0] rot_wide;
    logic        s2_advance;
    logic        s1_accept;

    assign s2_advance   = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_advance;
    assign s1_accept    = bus.in_valid && bus.in_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        s1_res   = RESULT_ZERO;
        // Rotating the doubled word avoids the 16-bit shift artefact when amt is 0.
        rot_wide = {s1_data, s1_data} >> s1_amt;
        case (s1_op)
            OP_SLL:  s1_res.data = s1_data << s1_amt;
            OP_SRA:  s1_res.data = $signed(s1_data) >>> s1_amt;
            OP_ROR:  s1_res.data = rot_wide[15:0];
            default: s1_res.err  = 1'b1;
        endcase
        s1_res.z = (s1_res.data == 16'h0000);
        s1_res.n = s1_res.data[15];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
        if (rst || flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (s2_advance)   s2_valid <= s1_valid;
        end
    end

    // Payload registers follow the handshake only; flush never touches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the S2 payload must reset to the zero-result encoding; S1 is reset only to stay deterministic.
            s1_op   <= OP_SLL;
            s1_data <= 16'h0000;
            s1_amt  <= 4'd0;
            s2_res  <= RESULT_ZERO;
        end else begin
            if (s1_accept) begin
                s1_op   <= op_e'(bus.in_op);
                s1_data <= bus.in_data;
                s1_amt  <= bus.in_amt;
            end
            if (s2_advance && s1_valid) s2_res <= s1_res;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_res.data;
    assign bus.out_z     = s2_res.z;
    assign bus.out_n     = s2_res.n;
    assign bus.out_err   = s2_res.err;
endmodule

// File: tb/tb_shift_ex_stage.sv
// Self-checking bench for shift_ex_stage: directed scenarios plus a random stream
// scored against an arithmetic reference model.
module tb_shift_ex_stage;
    typedef struct packed {
        logic [15:0] data;
        logic        z;
        logic        n;
        logic        err;
    } res_t;

    logic clk;
    logic rst;
    logic flush;
    int   n_cmp;
    int   n_bad;
    res_t exp_q[$];

    shift_ex_stage_if bus ();

    shift_ex_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference model from plain integer arithmetic.
    function automatic res_t model(input logic [1:0] op, input logic [15:0] d, input logic [3:0] amt);
        longint v;
        longint p;
        longint r;
        res_t   res;
        v       = longint'(d);
        p       = longint'(1) << amt;
        res.err = 1'b0;
        case (op)
            2'd0: r = (v * p) % 65536;
            2'd1: begin
                if (v >= 32768) v = v - 65536;
                if (v < 0) r = -((-v + p - 1) / p);
                else       r = v / p;
                r = (r + 65536) % 65536;
            end
            2'd2: r = ((v / p) + (v % p) * (65536 / p)) % 65536;
            default: begin
                r       = 0;
                res.err = 1'b1;
            end
        endcase
        res.data = 16'(r);
        res.z    = (r == 0);
        res.n    = (r >= 32768);
        return res;
    endfunction

    // One clock: sample handshake just before the edge, return 1 time unit after it.
    task automatic tick(output bit acc, output bit con, output res_t got);
        #1;
        acc = bus.in_valid && bus.in_ready && !rst && !flush;
        con = bus.out_valid && bus.out_ready;
        got = '{bus.out_data, bus.out_z, bus.out_n, bus.out_err};
        @(posedge clk);
        #1;
    endtask

    function automatic res_t dut_out();
        return '{bus.out_data, bus.out_z, bus.out_n, bus.out_err};
    endfunction

    task automatic drive_op(input logic [1:0] op, input logic [15:0] d, input logic [3:0] amt);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_amt   = amt;
    endtask

    task automatic test_reset();
        bit   acc, con;
        res_t got;
        rst = 1'b1;
        tick(acc, con, got);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_cmp++;
        if (dut_out() !== res_t'({16'h0000, 1'b1, 1'b0, 1'b0})) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h", dut_out(), res_t'({16'h0000, 1'b1, 1'b0, 1'b0}));
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready_during: got %b expected 1", bus.in_ready);
        end
        rst = 1'b0;
        tick(acc, con, got);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_after: in_ready %b out_valid %b expected 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic_ops();
        logic [1:0]  ops[4]  = '{2'd0, 2'd1, 2'd2, 2'd2};
        logic [15:0] dats[4] = '{16'h8001, 16'h8000, 16'h0001, 16'h1234};
        logic [3:0]  amts[4] = '{4'd1, 4'd15, 4'd1, 4'd0};
        res_t        exps[4] = '{{16'h0002, 1'b0, 1'b0, 1'b0}, {16'hFFFF, 1'b0, 1'b1, 1'b0},
                                 {16'h8000, 1'b0, 1'b1, 1'b0}, {16'h1234, 1'b0, 1'b0, 1'b0}};
        bit   acc, con;
        res_t got;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_op(ops[i], dats[i], amts[i]);
            tick(acc, con, got);
            bus.in_valid = 1'b0;
            n_cmp++;
            if (acc !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL basic_latency1[%0d]: accepted %b out_valid %b expected 1/0", i, acc, bus.out_valid);
            end
            tick(acc, con, got);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || dut_out() !== exps[i]) begin
                n_bad++;
                $display("FAIL basic_result[%0d]: valid %b got %h expected %h", i, bus.out_valid, dut_out(), exps[i]);
            end
            tick(acc, con, got);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  ops[3];
        logic [15:0] dats[3];
        logic [3:0]  amts[3];
        res_t        first;
        res_t        exp;
        bit          acc, con;
        res_t        got;
        int          k = 0;
        int          got_n = 0;
        int          cy = 0;
        for (int i = 0; i < 3; i++) begin
            ops[i]  = 2'($urandom_range(0, 2));
            dats[i] = 16'($urandom);
            amts[i] = 4'($urandom);
        end
        first = model(ops[0], dats[0], amts[0]);
        while (got_n < 3 && cy < 30) begin
            bus.out_ready = (cy >= 4);
            if (k < 3) drive_op(ops[k], dats[k], amts[k]);
            else       bus.in_valid = 1'b0;
            if (cy == 2) begin
                #1;
                n_cmp++;
                if (bus.in_ready !== 1'b0 || k != 2) begin
                    n_bad++;
                    $display("FAIL bp_in_ready_fall: in_ready %b accepts %0d expected 0/2", bus.in_ready, k);
                end
            end
            tick(acc, con, got);
            if (acc) begin
                exp_q.push_back(model(ops[k], dats[k], amts[k]));
                k++;
            end
            if (con) begin
                exp = exp_q.pop_front();
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL bp_order[%0d]: got %h expected %h", got_n, got, exp);
                end
                got_n++;
            end
            if (cy >= 1 && cy <= 3) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || dut_out() !== first) begin
                    n_bad++;
                    $display("FAIL bp_hold[%0d]: valid %b got %h expected %h", cy, bus.out_valid, dut_out(), first);
                end
            end
            cy++;
        end
        n_cmp++;
        if (got_n != 3) begin
            n_bad++;
            $display("FAIL bp_count: got %0d results expected 3", got_n);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(acc, con, got);
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_no_dup[%0d]: out_valid %b expected 0", i, bus.out_valid);
            end
        end
        exp_q.delete();
    endtask

    task automatic test_illegal();
        logic [15:0] d;
        logic [3:0]  a;
        bit          acc, con;
        res_t        got;
        d = 16'($urandom);
        a = 4'($urandom);
        bus.out_ready = 1'b1;
        drive_op(2'b11, 16'hFFFF, 4'($urandom));
        tick(acc, con, got);
        drive_op(2'b10, d, a);
        tick(acc, con, got);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || dut_out() !== res_t'({16'h0000, 1'b1, 1'b0, 1'b1})) begin
            n_bad++;
            $display("FAIL illegal_result: valid %b got %h expected %h", bus.out_valid, dut_out(),
                     res_t'({16'h0000, 1'b1, 1'b0, 1'b1}));
        end
        tick(acc, con, got);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || dut_out() !== model(2'b10, d, a) || bus.out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_next_legal: valid %b got %h expected %h", bus.out_valid, dut_out(), model(2'b10, d, a));
        end
        tick(acc, con, got);
    endtask

    task automatic test_flush();
        logic [15:0] d;
        logic [3:0]  a;
        res_t        first;
        bit          acc, con;
        res_t        got;
        int          seen = 0;
        d     = 16'($urandom);
        a     = 4'($urandom);
        first = model(2'b00, d, a);
        bus.out_ready = 1'b0;
        drive_op(2'b00, d, a);
        tick(acc, con, got);
        drive_op(2'b01, 16'($urandom), 4'($urandom));
        tick(acc, con, got);
        drive_op(2'b10, 16'($urandom), 4'($urandom));
        flush = 1'b1;
        tick(acc, con, got);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_full: out_valid %b in_ready %b expected 0/1", bus.out_valid, bus.in_ready);
        end
        n_cmp++;
        if (bus.out_data !== first.data) begin
            n_bad++;
            $display("FAIL flush_data_kept: got %h expected %h", bus.out_data, first.data);
        end
        bus.out_ready = 1'b1;
        drive_op(2'b00, 16'($urandom), 4'($urandom));
        flush = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_offer_ready: got %b expected 1", bus.in_ready);
        end
        tick(acc, con, got);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(acc, con, got);
            if (bus.out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL flush_no_stale: got %0d stale results expected 0", seen);
        end
    endtask

    task automatic test_reset_midstream();
        bit   acc, con;
        res_t got;
        int   seen = 0;
        bus.out_ready = 1'b0;
        drive_op(2'($urandom_range(0, 2)), 16'($urandom), 4'($urandom));
        tick(acc, con, got);
        drive_op(2'($urandom_range(0, 2)), 16'hA5A5, 4'd3);
        tick(acc, con, got);
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_setup: out_valid %b expected 1", bus.out_valid);
        end
        rst = 1'b1;
        tick(acc, con, got);
        rst = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || dut_out() !== res_t'({16'h0000, 1'b1, 1'b0, 1'b0}) || bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_state: valid %b out %h in_ready %b expected 0/%h/1", bus.out_valid, dut_out(),
                     res_t'({16'h0000, 1'b1, 1'b0, 1'b0}), bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(acc, con, got);
            if (bus.out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL rstmid_no_result: got %0d results expected 0", seen);
        end
    endtask

    task automatic test_stream();
        bit          acc, con;
        res_t        got;
        res_t        exp;
        logic [1:0]  op;
        logic [15:0] d;
        logic [3:0]  a;
        int          sent = 0;
        int          recv = 0;
        int          cyc  = 0;
        exp_q.delete();
        while (recv < 900 && cyc < 20000) begin
            op = 2'($urandom);
            d  = 16'($urandom);
            a  = 4'($urandom);
            if (sent < 900 && $urandom_range(0, 3) != 0) drive_op(op, d, a);
            else bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick(acc, con, got);
            if (acc) begin
                exp_q.push_back(model(op, d, a));
                sent++;
            end
            if (con) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: unexpected result %h", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL stream_result[%0d]: got %h expected %h", recv, got, exp);
                    end
                end
                recv++;
            end
            cyc++;
        end
        n_cmp++;
        if (recv != 900 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stream_count: got %0d results, %0d pending expected 900/0", recv, exp_q.size());
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 102; c++) begin
            op = 2'($urandom);
            d  = 16'($urandom);
            a  = 4'($urandom);
            if (c < 100) drive_op(op, d, a);
            else bus.in_valid = 1'b0;
            tick(acc, con, got);
            if (c < 100) begin
                n_cmp++;
                if (!acc) begin
                    n_bad++;
                    $display("FAIL thru_accept[%0d]: got 0 expected 1", c);
                end else begin
                    exp_q.push_back(model(op, d, a));
                end
            end
            if (c >= 2) begin
                n_cmp++;
                if (!con || exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL thru_result[%0d]: consumed %b expected 1", c, con);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL thru_data[%0d]: got %h expected %h", c, got, exp);
                    end
                end
            end
        end
        tick(acc, con, got);
        n_cmp++;
        if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL thru_drain: out_valid %b pending %0d expected 0/0", bus.out_valid, exp_q.size());
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_data   = 16'h0000;
        bus.in_amt    = 4'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_ops();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_midstream();
        test_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/shift_ex_stage.md
SHIFT_EX_STAGE -- requirements
Module: shift_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port flush, input, 1 bit: discard all in-flight operations.
REQ-004 SHALL have port in_valid, input, 1 bit: upstream operation present.
REQ-005 SHALL have port in_ready, output, 1 bit: stage accepts an operation this cycle.
REQ-006 SHALL have port in_op, input, 2 bits: operation select; 00 = SLL, 01 = SRA, 10 = ROR, 11 = illegal.
REQ-007 SHALL have port in_data, input, 16 bits: operand to shift.
REQ-008 SHALL have port in_amt, input, 4 bits: shift amount, 0-15.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-011 SHALL have port out_data, output, 16 bits: shifted result.
REQ-012 SHALL have port out_z, output, 1 bit: result equals 0x0000.
REQ-013 SHALL have port out_n, output, 1 bit: equals out_data[15].
REQ-014 SHALL have port out_err, output, 1 bit: the operation was illegal.

Function
REQ-015 SHALL be a two-stage pipeline:
  - S1 registers op, data and amt.
  - S2 registers the computed result and flags.
  - Accept-to-out_valid latency is exactly 2 cycles when there is no backpressure.
REQ-016 SHALL transfer an operation on a cycle where in_valid and in_ready are both high; SHALL transfer a result on a cycle where out_valid and out_ready are both high.
REQ-017 SHALL advance S2 when it is empty or its result transfers; SHALL advance S1 into S2 under that condition.
REQ-018 SHALL drive in_ready = !s1_valid || s2_advances; in_ready is combinational and does not depend on in_valid.
REQ-019 SHALL, while stalled, hold out_data, out_z, out_n and out_err stable, and hold S1 contents unchanged.
REQ-020 SHALL compute SLL as a logical left shift, zero-filled.
REQ-021 SHALL compute SRA as an arithmetic right shift, filling with data[15].
REQ-022 SHALL compute ROR as a rotate right: (data >> amt) | (data << (16 - amt)), truncated to 16 bits.
REQ-023 SHALL return data unchanged for amt = 0 in all legal ops, including ROR (no 16-bit shift artefact).
REQ-024 SHALL, for op = 11, produce out_data = 0x0000, out_z = 1, out_n = 0, out_err = 1; the pipeline is not halted.
REQ-025 SHALL hold out_err at 0 for legal ops.
REQ-026 SHALL sustain one operation per cycle when out_ready is held high.
REQ-027 SHALL, on flush:
  - clear s1_valid and s2_valid at the next edge;
  - drop any operation offered in the same cycle, even if in_valid && in_ready;
  - drive out_valid = 0 the following cycle.
REQ-028 SHALL give flush no effect on data registers other than the valid bits.
REQ-029 SHALL give rst priority over flush and over the handshake.
REQ-030 SHALL make outputs other than out_valid and in_ready don't-care to consumers while out_valid = 0, but they SHALL still follow REQ-031.

Reset
REQ-031 SHALL, at the first edge with rst high, set:
  - s1_valid = 0, s2_valid = 0
  - out_valid = 0
  - out_data = 0x0000
  - out_z = 1, out_n = 0, out_err = 0
REQ-032 SHALL drive in_ready = 1 during and after reset.
REQ-033 SHALL, when rst is asserted mid-operation, discard all in-flight operations; no result is emitted afterwards.

Verification
REQ-034 SHALL cover the basic ops with out_ready = 1:
  - SLL 0x8001 by 1 -> 0x0002, z = 0, n = 0, two cycles after accept.
  - SRA 0x8000 by 15 -> 0xFFFF, n = 1.
  - ROR 0x0001 by 1 -> 0x8000.
  - ROR 0x1234 by 0 -> 0x1234.
REQ-035 SHALL cover backpressure: three back-to-back ops with out_ready = 0 for 4 cycles -> in_ready falls after 2 accepts, out_data holds the first result, then all three results emerge in order with none lost or duplicated.
REQ-036 SHALL cover an illegal op: op = 11, data 0xFFFF -> out_data 0x0000, out_z = 1, out_err = 1; the following legal op gives out_err = 0.
REQ-037 SHALL cover flush: flush asserted with S1 and S2 full and in_valid high -> out_valid = 0 the next cycle and no stale result ever appears.
REQ-038 SHALL cover reset mid-stream: rst for 1 cycle while out_valid = 1 and stalled -> out_valid = 0, out_data 0x0000, out_z = 1, in_ready = 1.
REQ-039 SHALL cover streaming: a random stream of 1000 ops with random out_ready -> results match a reference model in order, and throughput is 1/cycle whenever out_ready is held high.
